audio_chan_seq: RTL and testbench

AUDIO_CHAN_SEQ -- requirements
Module: audio_chan_seq

---
 rtl/audio_net_pkg.sv | 22 ++
 rtl/audio_chan_seq_sync.sv | 28 ++
 rtl/audio_chan_seq.sv | 102 ++++++++++
 tb/tb_audio_chan_seq.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/audio_net_pkg.sv
// Shared definitions for the audio channel sequencer: state codes and defaults.
package audio_net_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ARM   = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  localparam int DEF_FLOPS      = 2;
  localparam int DEF_CLR_CYCLES = 4;
  localparam int CLR_CNT_W      = 8;
  localparam int FRAME_CNT_W    = 16;

  // Frame counter step with saturation at all-ones.
  function automatic logic [FRAME_CNT_W-1:0] sat_inc(input logic [FRAME_CNT_W-1:0] v);
    return (v == {FRAME_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/audio_chan_seq_sync.sv
// Multi-flop level synchronizer (syncFlop) with synchronous active-low reset.
module syncFlop #(
  parameter int FLOPS = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [FLOPS-1:0] sync_q;
  logic [FLOPS-1:0] sync_d;

  // Shift the async level one stage per clock.
  always_comb begin
    sync_d    = sync_q << 1;
    sync_d[0] = d;
  end

  // Synchronizer stages; cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[FLOPS-1];

endmodule

// File: rtl/audio_chan_seq.sv
// Audio channel sequencer: IDLE -> CLEAR -> ARM -> RUN -> DRAIN, with a
// saturating frame counter and Moore-decoded datapath controls.
module audio_chan_seq
  import audio_net_pkg::*;
#(
  parameter int FLOPS      = DEF_FLOPS,
  parameter int CLR_CYCLES = DEF_CLR_CYCLES
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   enable_async,
  input  logic                   frame_strobe,
  output logic                   clear,
  output logic                   run,
  output logic                   busy,
  output logic [2:0]             state,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam logic [CLR_CNT_W-1:0] CLR_LOAD = CLR_CNT_W'(CLR_CYCLES - 1);

  logic                   en_sync;
  state_e                 state_q, state_d;
  logic [CLR_CNT_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  // enable_async is sampled only by this synchronizer.
  syncFlop #(.FLOPS(FLOPS)) u_sync (
    .clk   (clk),
    .rst_n (!srst),
    .d     (enable_async),
    .q     (en_sync)
  );

  // Next-state, clear countdown and frame counting.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (en_sync) begin
          state_d     = ST_CLEAR;
          clr_cnt_d   = CLR_LOAD;
          frame_cnt_d = '0;
        end
      end
      ST_CLEAR: begin
        // Losing enable wins over the countdown finishing.
        if (!en_sync)             state_d = ST_IDLE;
        else if (clr_cnt_q == '0) state_d = ST_ARM;
        else                      clr_cnt_d = clr_cnt_q - 1'b1;
      end
      ST_ARM: begin
        // The arming strobe starts the run but is not itself counted.
        if (!en_sync)          state_d = ST_IDLE;
        else if (frame_strobe) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (frame_strobe) frame_cnt_d = sat_inc(frame_cnt_q);
        if (!en_sync)     state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Only a frame boundary ends the drain; re-enable is ignored here.
        if (frame_strobe) begin
          frame_cnt_d = sat_inc(frame_cnt_q);
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= ST_IDLE;
      clr_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Moore output decode from the registered state.
  always_comb begin
    clear = 1'b0;
    run   = 1'b0;
    case (state_q)
      ST_IDLE, ST_CLEAR: clear = 1'b1;
      ST_RUN, ST_DRAIN:  run   = 1'b1;
      default: ;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign state     = state_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_audio_chan_seq.sv
// Directed bench for audio_chan_seq (FLOPS=2, CLR_CYCLES=4) with an
// expected-value queue checked by an independent monitor.
module tb_audio_chan_seq;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLR   = 3'd1;
  localparam logic [2:0] ARM   = 3'd2;
  localparam logic [2:0] RUN   = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;
  localparam int W = 22;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        enable_async = 1'b0;
  logic        frame_strobe = 1'b0;
  logic        clear, run, busy;
  logic [2:0]  state;
  logic [15:0] frame_cnt;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;

  audio_chan_seq #(.FLOPS(2), .CLR_CYCLES(4)) dut (
    .clk          (clk),
    .srst         (srst),
    .enable_async (enable_async),
    .frame_strobe (frame_strobe),
    .clear        (clear),
    .run          (run),
    .busy         (busy),
    .state        (state),
    .frame_cnt    (frame_cnt)
  );

  // Clock
  always #5 clk = ~clk;

  // Expected output word {state, clear, run, busy, frame_cnt} from the state table.
  function automatic logic [W-1:0] ex(input logic [2:0] st, input logic [15:0] c);
    logic cl, rn, bz;
    cl = (st == IDLE) || (st == CLR);
    rn = (st == RUN) || (st == DRAIN);
    bz = (st != IDLE);
    return {st, cl, rn, bz, c};
  endfunction

  // Drive one clock of inputs; optionally queue the expected post-edge outputs.
  task automatic cyc(input logic s, input logic en, input logic fs,
                     input logic chk, input logic [W-1:0] e, input string tag);
    @(negedge clk);
    srst         = s;
    enable_async = en;
    frame_strobe = fs;
    @(posedge clk);
    #1;
    if (chk) begin
      exp_q.push_back(e);
      tag_q.push_back(tag);
    end
  endtask

  task automatic go(input logic en, input logic fs, input logic [2:0] st,
                    input logic [15:0] c, input string tag);
    cyc(1'b0, en, fs, 1'b1, ex(st, c), tag);
  endtask

  // Enable from IDLE (en_sync low) through the clear window into ARM.
  task automatic enable_to_arm(input logic [15:0] held, input string tag);
    go(1, 0, IDLE, held, {tag, "_sync1"});
    go(1, 0, IDLE, held, {tag, "_sync2"});
    go(1, 0, CLR, 16'd0, {tag, "_clear_entry"});
    go(1, 0, CLR, 16'd0, {tag, "_clear2"});
    go(1, 0, CLR, 16'd0, {tag, "_clear3"});
    go(1, 0, CLR, 16'd0, {tag, "_clear4"});
    go(1, 0, ARM, 16'd0, {tag, "_arm_entry"});
  endtask

  // Monitor: compare DUT outputs against the queue head away from the active edge.
  always @(negedge clk) begin
    logic [W-1:0] e, act;
    string t;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      act = {state, clear, run, busy, frame_cnt};
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL %s: got st=%0d clr=%0b run=%0b busy=%0b cnt=%h, want st=%0d clr=%0b run=%0b busy=%0b cnt=%h",
                 t, act[21:19], act[18], act[17], act[16], act[15:0],
                 e[21:19], e[18], e[17], e[16], e[15:0]);
      end
    end
  end

  // Stimulus
  initial begin
    int guard;
    cyc(1, 0, 0, 1, ex(IDLE, 16'd0), "reset_a");
    cyc(1, 0, 0, 1, ex(IDLE, 16'd0), "reset_b");

    // Enable -> CLEAR at FLOPS+1, four CLEAR cycles, ARM.
    enable_to_arm(16'd0, "en");
    go(1, 0, ARM, 16'd0, "arm_hold_a");
    go(1, 0, ARM, 16'd0, "arm_hold_b");
    go(1, 1, RUN, 16'd0, "arm_to_run");
    go(1, 1, RUN, 16'd1, "run_strobe1");
    go(1, 0, RUN, 16'd1, "run_nostrobe");
    go(1, 1, RUN, 16'd2, "run_strobe2");
    go(1, 1, RUN, 16'd3, "run_strobe3");
    go(0, 0, RUN, 16'd3, "drop_en_a");
    go(0, 0, RUN, 16'd3, "drop_en_b");
    go(0, 0, DRAIN, 16'd3, "drain_entry");
    go(0, 0, DRAIN, 16'd3, "drain_wait");
    go(0, 1, IDLE, 16'd4, "drain_exit");

    // Enable lost mid-clear, with the countdown just reaching zero.
    go(1, 0, IDLE, 16'd4, "idle_hold_a");
    go(1, 0, IDLE, 16'd4, "idle_hold_b");
    go(1, 0, CLR, 16'd0, "cnt_cleared");
    go(1, 0, CLR, 16'd0, "clr_count2");
    go(0, 0, CLR, 16'd0, "clr_drop_a");
    go(0, 0, CLR, 16'd0, "clr_drop_b");
    go(0, 0, IDLE, 16'd0, "clear_abort");
    go(0, 0, IDLE, 16'd0, "abort_idle");

    // Strobe and en_sync fall in the same ARM cycle.
    enable_to_arm(16'd0, "tie");
    go(0, 0, ARM, 16'd0, "tie_arm_a");
    go(0, 0, ARM, 16'd0, "tie_arm_b");
    go(0, 1, IDLE, 16'd0, "arm_tie_idle");

    // Re-enable during DRAIN does not abort it; IDLE then restarts.
    enable_to_arm(16'd0, "re");
    go(1, 1, RUN, 16'd0, "re_run");
    go(0, 0, RUN, 16'd0, "re_drop_a");
    go(0, 0, RUN, 16'd0, "re_drop_b");
    go(0, 0, DRAIN, 16'd0, "re_drain");
    go(1, 0, DRAIN, 16'd0, "re_drain_en_a");
    go(1, 0, DRAIN, 16'd0, "re_drain_en_b");
    go(1, 0, DRAIN, 16'd0, "re_drain_en_c");
    go(1, 1, IDLE, 16'd1, "drain_reenable");
    go(1, 0, CLR, 16'd0, "restart_clear");
    go(1, 0, CLR, 16'd0, "restart_clear2");
    go(1, 0, CLR, 16'd0, "restart_clear3");
    go(1, 0, CLR, 16'd0, "restart_clear4");
    go(1, 0, ARM, 16'd0, "restart_arm");
    go(1, 1, RUN, 16'd0, "sat_run");

    // Long run to the saturation point.
    for (int i = 0; i < 65534; i++) cyc(0, 1, 1, 0, '0, "");
    go(1, 0, RUN, 16'hFFFE, "sat_fffe");
    go(1, 1, RUN, 16'hFFFF, "sat_ffff");
    go(1, 1, RUN, 16'hFFFF, "sat_hold_a");
    go(1, 1, RUN, 16'hFFFF, "sat_hold_b");

    // Reset mid-run: no drain, everything back to reset values.
    cyc(1, 1, 1, 1, ex(IDLE, 16'd0), "srst_mid_run");
    go(1, 0, IDLE, 16'd0, "post_rst_sync1");
    go(1, 0, IDLE, 16'd0, "post_rst_sync2");
    go(1, 0, CLR, 16'd0, "post_rst_clear");

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_queue: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule
